// File: rtl/sram_arbiter_if.sv
// Bundles the two requester ports, shared read data and the async SRAM pins
// into one interface; the arbiter uses the slave modport and the environment uses master.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);

  // Port A: LC-3 CPU memory path
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_done;

  // Port B: debug / loader path
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_done;

  logic [DATA_W-1:0] rdata;

  // Async SRAM pins; every strobe is active-low
  logic [ADDR_W-1:0] Mem_ADDR;
  logic [DATA_W-1:0] Mem_DQ_out;
  logic              Mem_DQ_oe;
  logic [DATA_W-1:0] Mem_DQ_in;
  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  Mem_DQ_in,
    output a_done, b_done, rdata,
    output Mem_ADDR, Mem_DQ_out, Mem_DQ_oe,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output Mem_DQ_in,
    input  a_done, b_done, rdata,
    input  Mem_ADDR, Mem_DQ_out, Mem_DQ_oe,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sequencing every access to the single async SRAM between
// the CPU port (A) and the debug/loader port (B), with fixed multi-cycle strobe timing.
module sram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int ACC_CYCLES = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  sram_arbiter_if.slave mem_if,
  output logic          o_state
);

  // Handshake: a requester raises req with we/addr/wdata valid and holds req
  // high until its done pulses for one cycle; fields are sampled only at grant,
  // and a port whose done is high this cycle is not eligible for a new grant.

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_last;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dq_out;
  logic              r_dq_oe;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_a_done;
  logic              r_b_done;
  logic [DATA_W-1:0] r_rdata;

  state_t            w_state_nxt;
  logic [3:0]        w_cnt_nxt;
  logic              w_last_nxt;
  logic              w_owner_nxt;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_dq_out_nxt;
  logic              w_dq_oe_nxt;
  logic              w_oe_n_nxt;
  logic              w_we_n_nxt;
  logic              w_a_done_nxt;
  logic              w_b_done_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;

  logic              w_a_elig;
  logic              w_b_elig;
  logic              w_gnt_b;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // The done mask stops a requester that is still dropping req from being re-granted.
  assign w_a_elig    = mem_if.a_req & ~r_a_done;
  assign w_b_elig    = mem_if.b_req & ~r_b_done;
  assign w_gnt_b     = w_b_elig & (~w_a_elig | ~r_last);
  assign w_sel_we    = w_gnt_b ? mem_if.b_we    : mem_if.a_we;
  assign w_sel_addr  = w_gnt_b ? mem_if.b_addr  : mem_if.a_addr;
  assign w_sel_wdata = w_gnt_b ? mem_if.b_wdata : mem_if.a_wdata;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_dq_out <= '0;
      r_dq_oe  <= 1'b0;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last   <= w_last_nxt;
      r_owner  <= w_owner_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_dq_out <= w_dq_out_nxt;
      r_dq_oe  <= w_dq_oe_nxt;
      r_oe_n   <= w_oe_n_nxt;
      r_we_n   <= w_we_n_nxt;
      r_a_done <= w_a_done_nxt;
      r_b_done <= w_b_done_nxt;
      r_rdata  <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_nxt   = r_last;
    w_owner_nxt  = r_owner;
    w_we_nxt     = r_we;
    w_addr_nxt   = r_addr;
    w_dq_out_nxt = r_dq_out;
    w_dq_oe_nxt  = r_dq_oe;
    w_oe_n_nxt   = r_oe_n;
    w_we_n_nxt   = r_we_n;
    w_a_done_nxt = 1'b0;
    w_b_done_nxt = 1'b0;
    w_rdata_nxt  = r_rdata;

    case (r_state)
      S_IDLE: begin
        w_oe_n_nxt  = 1'b1;
        w_we_n_nxt  = 1'b1;
        w_dq_oe_nxt = 1'b0;
        if (w_a_elig | w_b_elig) begin
          w_state_nxt  = S_ACCESS;
          w_owner_nxt  = w_gnt_b;
          w_last_nxt   = w_gnt_b;
          w_we_nxt     = w_sel_we;
          w_addr_nxt   = w_sel_addr;
          w_dq_out_nxt = w_sel_wdata;
          w_cnt_nxt    = CNT_INIT;
          // Reads and writes use disjoint strobes, so DQ is never driven while OE is low.
          w_oe_n_nxt   = w_sel_we;
          w_we_n_nxt   = ~w_sel_we;
          w_dq_oe_nxt  = w_sel_we;
        end
      end
      S_ACCESS: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = S_IDLE;
          w_oe_n_nxt  = 1'b1;
          w_we_n_nxt  = 1'b1;
          w_dq_oe_nxt = 1'b0;
          if (!r_we) begin
            w_rdata_nxt = mem_if.Mem_DQ_in;
          end
          if (r_owner) begin
            w_b_done_nxt = 1'b1;
          end else begin
            w_a_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_if.a_done     = r_a_done;
  assign mem_if.b_done     = r_b_done;
  assign mem_if.rdata      = r_rdata;
  assign mem_if.Mem_ADDR   = r_addr;
  assign mem_if.Mem_DQ_out = r_dq_out;
  assign mem_if.Mem_DQ_oe  = r_dq_oe;
  assign mem_if.Mem_OE     = r_oe_n;
  assign mem_if.Mem_WE     = r_we_n;
  assign mem_if.Mem_CE     = 1'b0;
  assign mem_if.Mem_UB     = 1'b0;
  assign mem_if.Mem_LB     = 1'b0;
  assign o_state           = r_state;

endmodule
